rr_arb_ctrl: RTL and testbench
==============================

Name: rr_arb_ctrl

Overview:
- Sequential round-robin arbiter that shares one resource among 8 requesters.
- Wraps rotating-priority selection around a registered one-hot grant, with grant hold and fairness pointer.
- Sits between the requesters and the shared resource.
- Replaces fixed lowest-index priority, which starves high indices under sustained load.

Parameters:
N, 8, number of requesters (index width IW = clog2(N), 3 at default)
MAX_HOLD, 16, max consecutive grant cycles per holder (used only with RR_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  N  request vector, bit i = requester i
gnt  output  N  registered one-hot grant, all-zero when idle
gnt_idx  output  IW  binary index of current/last holder
gnt_valid  output  1  high whenever gnt is non-zero
timeout  output  1  one-cycle pulse on forced revoke (tied 0 when feature is compiled out)

Behaviour:
Reset:
- Async assert clears gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- Takes effect immediately, including mid-grant; no grant survives reset.
- Deassertion is synchronous to clk.

ptr (internal, IW bits):
- Highest-priority index for the next arbitration.

IDLE state:
- req==0: stay in IDLE, outputs stay 0.
- req!=0: select the first set bit scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap).
- At the next edge: gnt=one-hot(sel), gnt_idx=sel, gnt_valid=1, hold_cnt=0, state=GRANT.
- Latency: req sampled at edge k gives gnt visible after edge k+1 (1 cycle).

GRANT state:
- Grant is held while req[gnt_idx]=1. No preemption; other requests are ignored.
- hold_cnt increments each cycle, saturating.
- At the edge where req[gnt_idx]=0 is sampled:
  - gnt=0, gnt_valid=0.
  - ptr=(gnt_idx+1) mod N.
  - state=IDLE.
  - gnt_idx keeps the last holder.
- Guaranteed minimum one dead cycle (gnt=0) between consecutive grants.

Boundary conditions:
- Wrap: release of idx N-1 sets ptr=0.
- A requester dropping and re-raising in the same dead cycle is treated as a new request and is subject to the rotated ptr.
- Simultaneous release by the holder and a new request from others: the new request is arbitrated in the following IDLE cycle.
- Exactly one gnt bit is ever high. The invariant gnt_valid == |gnt always holds.

Optional Feature:
Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt==MAX_HOLD-1 and req[gnt_idx] is still 1, the next edge forces a revoke.
  - Revoke: gnt=0, gnt_valid=0, ptr=(gnt_idx+1) mod N, state=IDLE, timeout=1 for exactly that one cycle.
  - A holder that keeps requesting rejoins normal round-robin.
  - Normal release takes precedence if req[gnt_idx]=0 on the same cycle; timeout stays 0.
- Undefined:
  - No hold_cnt, timeout tied 0.
  - A holder can keep the grant indefinitely.

Test Plan:
1. rst_n=0 while req=8'hFF -> gnt=8'h00, gnt_valid=0, gnt_idx=0. Release reset with req=0 -> outputs remain 0.
2. From reset (ptr=0), req=8'b00101010 -> one edge later gnt=8'b00000010, gnt_idx=1. Grant held for 5 cycles while req[1]=1, with req[3] and req[5] ignored.
3. Drop req[1] (req=8'b00101000) -> next edge gnt=0. Following edge gnt=8'b00001000, gnt_idx=3 (ptr=2).
4. Wrap: holder idx 7 with req=8'b10000001. Drop req[7] -> dead cycle, then gnt=8'b00000001, gnt_idx=0. Assert rst_n=0 mid-grant -> gnt=0 immediately, without waiting for a clk edge.
5. Fairness: req=8'hFF, each holder drops its bit 2 cycles after being granted and re-raises it after the dead cycle -> grant order 0,1,2,...,7,0. No index is granted twice before all others.
6. With RR_ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'b00000100 held constant:
   - gnt=8'b00000100 for 4 cycles, then gnt=0 with a single-cycle timeout=1, then re-granted after the dead cycle.
   - Without the macro, the grant is held for 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter for N requesters with a registered one-hot grant held until release.
// Optional forced revoke after MAX_HOLD cycles when compiled with RR_ARB_TIMEOUT_EN.
module rr_arb_ctrl #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  output logic          timeout
);

  if (N < 2 || MAX_HOLD < 1) begin : g_param_chk
    $error("rr_arb_ctrl: N must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] sel_s;
  logic [IW-1:0] ptr_next_s;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // First set request bit scanning upward from p, wrapping past N-1.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(p) + i) % N;
      if (!found && r[idx[IW-1:0]]) begin
        sel   = idx[IW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] idx);
    return (idx == IW'(N - 1)) ? IW'(0) : idx + IW'(1);
  endfunction

  assign sel_s      = rr_pick(req, ptr_q);
  assign ptr_next_s = inc_wrap(gnt_idx_q);

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          gnt_d       = onehot(sel_s);
          gnt_idx_d   = sel_s;
          gnt_valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end else begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        // A holder that lets go always wins over the timeout, so no pulse then.
        if (!req[gnt_idx_q]) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = ptr_next_s;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            ptr_d       = ptr_next_s;
            timeout_d   = 1'b1;
          end else if (hold_cnt_q != HW'(MAX_HOLD)) begin
            hold_cnt_d  = hold_cnt_q + HW'(1);
          end else begin
            hold_cnt_d  = hold_cnt_q;
          end
`else
          state_d     = GRANT;
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Scoreboard bench for rr_arb_ctrl: a cycle model pushes expected outputs as each
// request vector is driven; they are popped and compared one edge later.
module tb_rr_arb_ctrl;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int  MAXH  = 4;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  MAXH  = 16;
  localparam bit  TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_arb_ctrl #(.N(8), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       t;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  bit   m_busy;
  int   m_ptr;
  int   m_idx;
  int   m_hold;
  logic [7:0] m_gnt;
  logic       m_valid;
  logic       m_to;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_hold = 0;
    m_gnt = 8'h00; m_valid = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit found;
    m_to = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int j;
        j = (m_ptr + k) % 8;
        if (!found && r[j]) begin
          found = 1'b1; m_idx = j;
        end
      end
      if (found) begin
        m_busy = 1'b1; m_hold = 0; m_valid = 1'b1;
        m_gnt = 8'h01 << m_idx;
      end
    end else if (!r[m_idx]) begin
      m_busy = 1'b0; m_gnt = 8'h00; m_valid = 1'b0; m_ptr = (m_idx + 1) % 8;
    end else if (TO_EN && m_hold == MAXH - 1) begin
      m_busy = 1'b0; m_gnt = 8'h00; m_valid = 1'b0; m_ptr = (m_idx + 1) % 8; m_to = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  // Drive one request vector, predict, advance one edge, then compare.
  task automatic tick(input logic [7:0] r);
    exp_t e;
    req = r;
    model_step(r);
    sb_q.push_back('{g: m_gnt, i: 3'(m_idx), v: m_valid, t: m_to});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_gnt",       32'(gnt),       32'(e.g));
      check_eq("sb_gnt_idx",   32'(gnt_idx),   32'(e.i));
      check_eq("sb_gnt_valid", 32'(gnt_valid), 32'(e.v));
      check_eq("sb_timeout",   32'(timeout),   32'(e.t));
      check_eq("inv_valid",    32'(gnt_valid), 32'(|gnt));
      check_eq("inv_onehot0",  32'($onehot0(gnt)), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[$];
    int hi_cnt;
    int to_cnt;
    clk   = 1'b0;
    rst_n = 1'b0;
    req   = 8'hFF;
    model_reset();

    // 1. reset with all requesting, then release with no requests
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gnt",   32'(gnt),       32'h00);
    check_eq("rst_valid", 32'(gnt_valid), 32'h0);
    check_eq("rst_idx",   32'(gnt_idx),   32'h0);
    check_eq("rst_to",    32'(timeout),   32'h0);
    rst_n = 1'b1;
    repeat (3) tick(8'h00);
    check_eq("idle_gnt", 32'(gnt), 32'h00);

    // 2. first grant from ptr=0 goes to 1; held while 3 and 5 also request
    tick(8'b0010_1010);
    check_eq("t2_gnt", 32'(gnt),     32'h02);
    check_eq("t2_idx", 32'(gnt_idx), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick(8'b0010_1010);
      check_eq("t2_hold", 32'(gnt), 32'h02);
    end

    // 3. release of 1: dead cycle then 3 (ptr=2)
    tick(8'b0010_1000);
    check_eq("t3_dead", 32'(gnt), 32'h00);
    tick(8'b0010_1000);
    check_eq("t3_gnt", 32'(gnt),     32'h08);
    check_eq("t3_idx", 32'(gnt_idx), 32'd3);

    // 4. wrap: get 7 as holder, release it, next is 0; then async reset mid-grant
    tick(8'b0010_0000);
    check_eq("t4_dead0", 32'(gnt), 32'h00);
    tick(8'b1000_0001);
    check_eq("t4_gnt7", 32'(gnt), 32'h80);
    tick(8'b1000_0001);
    tick(8'b0000_0001);
    check_eq("t4_dead", 32'(gnt), 32'h00);
    tick(8'b0000_0001);
    check_eq("t4_gnt0", 32'(gnt),     32'h01);
    check_eq("t4_idx0", 32'(gnt_idx), 32'd0);
    tick(8'b1000_0001);
    check_eq("t4_pre_rst", 32'(gnt), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t4_async_gnt",   32'(gnt),       32'h00);
    check_eq("t4_async_valid", 32'(gnt_valid), 32'h0);
    check_eq("t4_async_idx",   32'(gnt_idx),   32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 5. fairness: everyone requests, each holder lets go after 2 cycles
    for (int k = 0; k < 9; k++) begin
      tick(8'hFF);
      check_eq("t5_idx", 32'(gnt_idx), 32'(k % 8));
      check_eq("t5_gnt", 32'(gnt),     32'(8'h01 << (k % 8)));
      order.push_back(int'(gnt_idx));
      tick(8'hFF);
      tick(8'hFF & ~(8'h01 << (k % 8)));
      check_eq("t5_dead", 32'(gnt), 32'h00);
    end
    for (int a = 0; a < 8; a++) begin
      for (int b = a + 1; b < 8; b++) begin
        check_eq("t5_unique", 32'(order[a] == order[b]), 32'd0);
      end
    end

    // 6. constant request from 2: forced revoke when enabled, indefinite hold otherwise
    do_reset();
    hi_cnt = 0;
    to_cnt = 0;
    if (TO_EN) begin
      tick(8'h04);
      while (gnt == 8'h04 && hi_cnt < 50) begin
        hi_cnt++;
        tick(8'h04);
      end
      check_eq("t6_hold_len",  32'(hi_cnt),  32'(MAXH));
      check_eq("t6_to_pulse",  32'(timeout), 32'd1);
      check_eq("t6_revoked",   32'(gnt),     32'h00);
      tick(8'h04);
      check_eq("t6_to_clear",  32'(timeout), 32'd0);
      check_eq("t6_regrant",   32'(gnt),     32'h04);
    end else begin
      for (int c = 0; c < 120; c++) begin
        tick(8'h04);
        if (gnt == 8'h04) hi_cnt++;
        if (timeout) to_cnt++;
      end
      check_eq("t6_hold_len", 32'(hi_cnt), 32'd120);
      check_eq("t6_no_to",    32'(to_cnt), 32'd0);
    end

    // normal release on the same cycle a revoke would fire gives no pulse
    do_reset();
    tick(8'h10);
    for (int c = 0; c < MAXH - 1; c++) tick(8'h10);
    tick(8'h00);
    check_eq("rel_vs_to_gnt", 32'(gnt),     32'h00);
    check_eq("rel_vs_to_to",  32'(timeout), 32'd0);
    tick(8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
